// File: rtl/sdp_y_op_cvt_lane_if.sv
// rtl/sdp_y_op_cvt_lane_if.sv - operand stream bundle for the Y-path operand converter lane
//
// Groups the input and output beat handshakes of the converter.
//   cvt_in_pvld / cvt_in_prdy / cvt_in_data    : signed operand stream from the EW read path
//   cvt_out_pvld / cvt_out_prdy / cvt_out_data : converted operand stream to the Y core
//   cvt_out_sat                                : beat was clamped during conversion
// Modports: slave = converter view, master = upstream/downstream environment view.

interface sdp_y_op_cvt_lane_if #(
    parameter int IN_DW  = 16,
    parameter int OUT_DW = 32
);
    logic              cvt_in_pvld;
    logic              cvt_in_prdy;
    logic [IN_DW-1:0]  cvt_in_data;
    logic              cvt_out_pvld;
    logic              cvt_out_prdy;
    logic [OUT_DW-1:0] cvt_out_data;
    logic              cvt_out_sat;

    modport slave (
        input  cvt_in_pvld,
        output cvt_in_prdy,
        input  cvt_in_data,
        output cvt_out_pvld,
        input  cvt_out_prdy,
        output cvt_out_data,
        output cvt_out_sat
    );

    modport master (
        output cvt_in_pvld,
        input  cvt_in_prdy,
        output cvt_in_data,
        input  cvt_out_pvld,
        output cvt_out_prdy,
        input  cvt_out_data,
        input  cvt_out_sat
    );
endinterface

// File: rtl/sdp_y_op_cvt_lane.sv
// rtl/sdp_y_op_cvt_lane.sv - two-stage (in - offset) * scale, round-shift, saturate operand converter
//
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, asynchronous active-low reset
//   cfg_cvt_bypass   : output is the sign-extended input
//   cfg_cvt_offset   : signed offset subtracted from the input
//   cfg_cvt_scale    : signed multiplier
//   cfg_cvt_truncate : rounding right-shift amount
//   cfg_sat_clr      : pulse, clears sat_cnt (wins over a same-cycle increment)
//   cvt              : operand in/out streams (slave modport)
//   sat_cnt          : saturated output beats, sticks at all-ones
//
// S1 holds the full-precision product, S2 holds the rounded and clamped result
// that drives the output directly.

module sdp_y_op_cvt_lane #(
    parameter int IN_DW  = 16,
    parameter int OUT_DW = 32,
    parameter int CNT_DW = 32
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  cfg_cvt_bypass,
    input  logic [31:0]           cfg_cvt_offset,
    input  logic [15:0]           cfg_cvt_scale,
    input  logic [5:0]            cfg_cvt_truncate,
    input  logic                  cfg_sat_clr,
    sdp_y_op_cvt_lane_if.slave    cvt,
    output logic [CNT_DW-1:0]     sat_cnt
);
    localparam int DIFF_W = 33;
    localparam int PROD_W = DIFF_W + 16;
    // Wide enough that the rounding constant for any shift up to 63 never overflows,
    // so shifts past the product width round to exactly 0.
    localparam int RW     = 65;

    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

    logic                     s1_vld_q, s1_vld_d;
    logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
    logic                     s2_vld_q, s2_vld_d;
    logic [OUT_DW-1:0]        s2_data_q, s2_data_d;
    logic                     s2_sat_q, s2_sat_d;
    logic [CNT_DW-1:0]        sat_cnt_q, sat_cnt_d;

    logic                     s1_rdy, s2_rdy, in_acc, s1_adv, out_hs;
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] diff_x, scale_x, prod_new;
    logic signed [RW-1:0]     prod_x, rnd, sum, r;
    logic [5:0]               t_m1;
    logic [OUT_DW-1:0]        clamp_data;
    logic                     clamp_sat;

    // Handshake: each stage accepts when empty or when its successor drains it.
    always_comb begin
        s2_rdy = !s2_vld_q | cvt.cvt_out_prdy;
        s1_rdy = !s1_vld_q | s2_rdy;
        in_acc = cvt.cvt_in_pvld & s1_rdy;
        s1_adv = s1_vld_q & s2_rdy;
        out_hs = s2_vld_q & cvt.cvt_out_prdy;
    end

    // S1 arithmetic: 33-bit difference times 16-bit scale is exact in 49 bits.
    always_comb begin
        diff     = {{(DIFF_W-IN_DW){cvt.cvt_in_data[IN_DW-1]}}, cvt.cvt_in_data}
                 - {cfg_cvt_offset[31], cfg_cvt_offset};
        diff_x   = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
        scale_x  = {{(PROD_W-16){cfg_cvt_scale[15]}}, cfg_cvt_scale};
        prod_new = diff_x * scale_x;
        if (cfg_cvt_bypass) begin
            prod_new = {{(PROD_W-IN_DW){cvt.cvt_in_data[IN_DW-1]}}, cvt.cvt_in_data};
        end
    end

    // S2 arithmetic: add half an LSB then arithmetic shift (round half toward +inf).
    always_comb begin
        prod_x = {{(RW-PROD_W){s1_prod_q[PROD_W-1]}}, s1_prod_q};
        t_m1   = cfg_cvt_truncate - 6'd1;
        rnd    = {{(RW-1){1'b0}}, 1'b1} << t_m1;
        sum    = prod_x + rnd;
        r      = prod_x;
        if (!cfg_cvt_bypass && (cfg_cvt_truncate != 6'd0)) begin
            r = sum >>> cfg_cvt_truncate;
        end
        clamp_data = r[OUT_DW-1:0];
        clamp_sat  = 1'b0;
        if (r > SAT_MAX) begin
            clamp_data = SAT_MAX[OUT_DW-1:0];
            clamp_sat  = 1'b1;
        end else if (r < SAT_MIN) begin
            clamp_data = SAT_MIN[OUT_DW-1:0];
            clamp_sat  = 1'b1;
        end
    end

    always_comb begin
        s1_vld_d  = s1_rdy ? cvt.cvt_in_pvld : s1_vld_q;
        s1_prod_d = in_acc ? prod_new : s1_prod_q;
        s2_vld_d  = s2_rdy ? s1_vld_q : s2_vld_q;
        s2_data_d = s1_adv ? clamp_data : s2_data_q;
        s2_sat_d  = s1_adv ? clamp_sat : s2_sat_q;

        sat_cnt_d = sat_cnt_q;
        if (cfg_sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_hs && s2_sat_q && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld_q  <= 1'b0;
            s1_prod_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_sat_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_prod_q <= s1_prod_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            s2_sat_q  <= s2_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign cvt.cvt_in_prdy  = s1_rdy;
    assign cvt.cvt_out_pvld = s2_vld_q;
    assign cvt.cvt_out_data = s2_data_q;
    assign cvt.cvt_out_sat  = s2_sat_q;
    assign sat_cnt          = sat_cnt_q;

endmodule

// File: tb/tb_sdp_y_op_cvt_lane.sv
// tb/tb_sdp_y_op_cvt_lane.sv - bench for the Y-path operand converter lane

module tb_sdp_y_op_cvt_lane;
    localparam int CNT_DW  = 4;
    localparam logic [63:0] CNT_MAX = 64'((1 << CNT_DW) - 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_bypass = 1'b0;
    logic [31:0]       cfg_offset = '0;
    logic [15:0]       cfg_scale = '0;
    logic [5:0]        cfg_trunc = '0;
    logic              cfg_clr = 1'b0;
    logic [CNT_DW-1:0] sat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] data;
        bit          sat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_cnt = '0;
    bit          stall_prev = 0;
    logic [31:0] hold_data;
    bit          hold_sat;

    sdp_y_op_cvt_lane_if #(.IN_DW(16), .OUT_DW(32)) cvt_if ();

    sdp_y_op_cvt_lane #(.IN_DW(16), .OUT_DW(32), .CNT_DW(CNT_DW)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rst_n),
        .cfg_cvt_bypass   (cfg_bypass),
        .cfg_cvt_offset   (cfg_offset),
        .cfg_cvt_scale    (cfg_scale),
        .cfg_cvt_truncate (cfg_trunc),
        .cfg_sat_clr      (cfg_clr),
        .cvt              (cvt_if),
        .sat_cnt          (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, floor division for rounding, then clamp.
    function automatic exp_t model(input logic signed [15:0] din);
        logic signed [127:0] v, off_w, sc_w, num, den, q;
        exp_t e;
        v     = din;
        off_w = $signed(cfg_offset);
        sc_w  = $signed(cfg_scale);
        if (!cfg_bypass) begin
            v = (v - off_w) * sc_w;
            if (cfg_trunc != 0) begin
                den = 128'sd1 <<< cfg_trunc;
                num = v + den / 2;
                q   = num / den;
                if (num < 0 && q * den != num) q = q - 1;
                v = q;
            end
        end
        e.sat = 0;
        if (v > 128'sd2147483647) begin
            e.data = 32'h7FFF_FFFF;
            e.sat  = 1;
        end else if (v < -128'sd2147483648) begin
            e.data = 32'h8000_0000;
            e.sat  = 1;
        end else begin
            e.data = v[31:0];
        end
        return e;
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   hs_sat;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = '0;
            stall_prev = 0;
        end else begin
            hs_sat = 0;
            chk("sat_cnt", 64'(sat_cnt), exp_cnt);
            if (stall_prev) begin
                chk("hold_pvld", 64'(cvt_if.cvt_out_pvld), 64'd1);
                chk("hold_data", 64'(cvt_if.cvt_out_data), 64'(hold_data));
                chk("hold_sat", 64'(cvt_if.cvt_out_sat), 64'(hold_sat));
            end
            if (cvt_if.cvt_out_pvld && cvt_if.cvt_out_prdy) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(cvt_if.cvt_out_data), 64'(e.data));
                    chk("out_sat", 64'(cvt_if.cvt_out_sat), 64'(e.sat));
                    hs_sat = e.sat;
                end
            end
            if (cvt_if.cvt_in_pvld && cvt_if.cvt_in_prdy) begin
                exp_q.push_back(model(cvt_if.cvt_in_data));
            end
            if (cfg_clr) exp_cnt = '0;
            else if (hs_sat && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1;
            stall_prev = cvt_if.cvt_out_pvld && !cvt_if.cvt_out_prdy;
            hold_data  = cvt_if.cvt_out_data;
            hold_sat   = cvt_if.cvt_out_sat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input bit byp, input logic [31:0] off, input logic [15:0] sc, input logic [5:0] t);
        cfg_bypass = byp;
        cfg_offset = off;
        cfg_scale  = sc;
        cfg_trunc  = t;
    endtask

    // One beat through an empty pipe with out_prdy=1; checks 2-cycle latency.
    task automatic xfer(input string tag, input logic [15:0] din, input logic [31:0] exp_d,
                        input bit exp_s, input bit clr);
        cvt_if.cvt_out_prdy = 1'b1;
        cvt_if.cvt_in_pvld  = 1'b1;
        cvt_if.cvt_in_data  = din;
        @(negedge clk);
        chk({tag, "_in_prdy"}, 64'(cvt_if.cvt_in_prdy), 64'd1);
        tick();
        cvt_if.cvt_in_pvld = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 64'(cvt_if.cvt_out_pvld), 64'd0);
        tick();
        cfg_clr = clr;
        @(negedge clk);
        chk({tag, "_lat2"}, 64'(cvt_if.cvt_out_pvld), 64'd1);
        chk({tag, "_data"}, 64'(cvt_if.cvt_out_data), 64'(exp_d));
        chk({tag, "_sat"}, 64'(cvt_if.cvt_out_sat), 64'(exp_s));
        tick();
        cfg_clr = 1'b0;
    endtask

    function automatic logic [15:0] rand_in();
        case ($urandom_range(3))
            0:       return ($urandom_range(1) != 0) ? 16'h7FFF : 16'h8000;
            1:       return 16'($urandom_range(20)) - 16'd10;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run_beats(input int n, input int pvld_pct, input int prdy_pct);
        int sent = 0;
        int guard = 0;
        bit acc;
        cvt_if.cvt_in_pvld = 1'b0;
        while (sent < n && guard < 4000) begin
            if (!cvt_if.cvt_in_pvld && $urandom_range(99) < pvld_pct) begin
                cvt_if.cvt_in_pvld = 1'b1;
                cvt_if.cvt_in_data = rand_in();
            end
            cvt_if.cvt_out_prdy = ($urandom_range(99) < prdy_pct);
            cfg_clr = ($urandom_range(39) == 0);
            @(negedge clk);
            acc = cvt_if.cvt_in_pvld && cvt_if.cvt_in_prdy;
            tick();
            if (acc) begin
                sent++;
                cvt_if.cvt_in_pvld = 1'b0;
            end
            guard++;
        end
        cvt_if.cvt_in_pvld = 1'b0;
        cfg_clr = 1'b0;
        chk("send_budget", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || cvt_if.cvt_out_pvld) && guard < 500) begin
            cvt_if.cvt_out_prdy = ($urandom_range(99) < 70);
            @(negedge clk);
            tick();
            guard++;
        end
        cvt_if.cvt_out_prdy = 1'b1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int nacc;
        bit acc;
        cvt_if.cvt_in_pvld  = 1'b0;
        cvt_if.cvt_in_data  = '0;
        cvt_if.cvt_out_prdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pvld", 64'(cvt_if.cvt_out_pvld), 64'd0);
        chk("rst_data", 64'(cvt_if.cvt_out_data), 64'd0);
        chk("rst_sat", 64'(cvt_if.cvt_out_sat), 64'd0);
        chk("rst_cnt", 64'(sat_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        set_cfg(1, 32'd0, 16'd0, 6'd0);
        xfer("byp8000", 16'h8000, 32'hFFFF_8000, 0, 0);

        set_cfg(0, 32'd5, 16'd3, 6'd0);
        xfer("lin10", 16'd10, 32'd15, 0, 0);
        xfer("lin_m1", 16'hFFFF, 32'hFFFF_FFEE, 0, 0);

        set_cfg(0, 32'd0, 16'd1, 6'd2);
        xfer("rnd6", 16'd6, 32'd2, 0, 0);
        xfer("rnd_m6", 16'hFFFA, 32'hFFFF_FFFF, 0, 0);
        xfer("rnd5", 16'd5, 32'd1, 0, 0);
        xfer("rnd7", 16'd7, 32'd2, 0, 0);

        set_cfg(0, 32'h8000_0000, 16'h7FFF, 6'd0);
        xfer("sat_pos", 16'h7FFF, 32'h7FFF_FFFF, 1, 0);
        chk("sat_cnt1", 64'(sat_cnt), 64'd1);
        cfg_scale = 16'h8000;
        xfer("sat_neg", 16'h7FFF, 32'h8000_0000, 1, 0);
        chk("sat_cnt2", 64'(sat_cnt), 64'd2);
        xfer("sat_clr", 16'h7FFF, 32'h8000_0000, 1, 1);
        chk("sat_cnt_clr", 64'(sat_cnt), 64'd0);

        // Backpressure: two beats fill the pipe, then release and expect 0..4 back to back.
        set_cfg(1, 32'd0, 16'd0, 6'd0);
        cvt_if.cvt_out_prdy = 1'b0;
        cvt_if.cvt_in_pvld  = 1'b1;
        cvt_if.cvt_in_data  = 16'd0;
        nacc = 0;
        repeat (6) begin
            @(negedge clk);
            acc = cvt_if.cvt_in_pvld && cvt_if.cvt_in_prdy;
            tick();
            if (acc) begin
                nacc++;
                cvt_if.cvt_in_data = 16'(nacc);
            end
        end
        chk("bp_accepts", 64'(nacc), 64'd2);
        chk("bp_in_prdy", 64'(cvt_if.cvt_in_prdy), 64'd0);
        cvt_if.cvt_out_prdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_pvld", 64'(cvt_if.cvt_out_pvld), 64'd1);
            chk("bp_data", 64'(cvt_if.cvt_out_data), 64'(i));
            acc = cvt_if.cvt_in_pvld && cvt_if.cvt_in_prdy;
            tick();
            if (acc) begin
                nacc++;
                if (nacc >= 5) cvt_if.cvt_in_pvld = 1'b0;
                else cvt_if.cvt_in_data = 16'(nacc);
            end
        end
        @(negedge clk);
        chk("bp_done", 64'(cvt_if.cvt_out_pvld), 64'd0);
        tick();

        // Reset with two saturating beats in flight.
        set_cfg(0, 32'h8000_0000, 16'h7FFF, 6'd0);
        xfer("pre_rst", 16'h7FFF, 32'h7FFF_FFFF, 1, 0);
        cvt_if.cvt_out_prdy = 1'b0;
        cvt_if.cvt_in_pvld  = 1'b1;
        cvt_if.cvt_in_data  = 16'h7FFF;
        tick();
        tick();
        cvt_if.cvt_in_pvld = 1'b0;
        chk("pre_rst_pvld", 64'(cvt_if.cvt_out_pvld), 64'd1);
        chk("pre_rst_cnt", 64'(sat_cnt), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_pvld", 64'(cvt_if.cvt_out_pvld), 64'd0);
        chk("arst_cnt", 64'(sat_cnt), 64'd0);
        chk("arst_in_prdy", 64'(cvt_if.cvt_in_prdy), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        set_cfg(1, 32'd0, 16'd0, 6'd0);
        tick();
        xfer("post_rst", 16'd3, 32'd3, 0, 0);
        @(negedge clk);
        chk("post_rst_stale", 64'(cvt_if.cvt_out_pvld), 64'd0);
        tick();

        // Randomized epochs; config only changes with the pipe empty.
        for (int ep = 0; ep < 12; ep++) begin
            logic [31:0] off;
            logic [15:0] sc;
            logic [5:0]  t;
            off = ($urandom_range(1) != 0) ? 32'($urandom_range(2000)) - 32'd1000 : 32'($urandom);
            sc  = ($urandom_range(1) != 0) ? 16'($urandom_range(64)) - 16'd32 : 16'($urandom);
            case ($urandom_range(9))
                0, 1, 2: t = 6'd0;
                3, 4:    t = 6'($urandom_range(63, 21));
                default: t = 6'($urandom_range(20, 1));
            endcase
            set_cfg(($urandom_range(3) == 0), off, sc, t);
            run_beats(40, 70, 60);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
